alu_mc_core: RTL and testbench

//  Parametrised multi-cycle ALU core, successor to the fixed 8-bit ALU. Width is generic.

---
 rtl/alu_mc_core_pkg.sv | 49 ++++
 rtl/alu_mc_core_if.sv | 22 ++
 rtl/alu_seq_muldiv.sv | 138 +++++++++++++
 rtl/alu_mc_core.sv | 192 +++++++++++++++++++
 tb/tb_alu_mc_core.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_mc_core_pkg.sv
// Shared types and constants for the multi-cycle ALU core.
// Optional divider build switch: ALU_DIV_EN (enables DIV/MOD opcodes).
package alu_mc_core_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'h00,
    OP_SUB = 5'h01,
    OP_AND = 5'h02,
    OP_OR  = 5'h03,
    OP_XOR = 5'h04,
    OP_NOT = 5'h05,
    OP_SHL = 5'h06,
    OP_SHR = 5'h07,
    OP_SAR = 5'h08,
    OP_ROL = 5'h09,
    OP_ROR = 5'h0A,
    OP_CMP = 5'h0B,
    OP_INC = 5'h0C,
    OP_DEC = 5'h0D,
    OP_MUL = 5'h10,
    OP_DIV = 5'h11,
    OP_MOD = 5'h12
  } alu_op_e;

  localparam int STAT_Z   = 0;
  localparam int STAT_N   = 1;
  localparam int STAT_C   = 2;
  localparam int STAT_V   = 3;
  localparam int STAT_ERR = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  // DIV/MOD only count as iterative when the divider is built in.
  function automatic logic is_multicycle(input logic [4:0] op);
    logic mc;
    case (op)
      OP_MUL: mc = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV, OP_MOD: mc = 1'b1;
`endif
      default: mc = 1'b0;
    endcase
    return mc;
  endfunction

endpackage

// File: rtl/alu_mc_core_if.sv
// Request/response bundle between a stimulus master and the ALU core.
interface alu_mc_core_if #(parameter int WIDTH = 8) ();
  logic             alu_enable;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic             alu_abort;
  logic             alu_ready;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_out;
  logic [4:0]       alu_status;

  modport master (
    output alu_enable, alu_op, alu_in1, alu_in2, alu_abort,
    input  alu_ready, alu_valid, alu_out, alu_status
  );

  modport slave (
    input  alu_enable, alu_op, alu_in1, alu_in2, alu_abort,
    output alu_ready, alu_valid, alu_out, alu_status
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier and (with ALU_DIV_EN) restoring divider.
// One iteration per busy cycle; the last iteration's result is presented
// combinationally together with done so the caller can register it.
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  import alu_mc_core_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               is_mul_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_s;
`ifdef ALU_DIV_EN
  logic               is_mod_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dvsr_r;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quo_s;
`endif

  // One multiply step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_s = acc_r;
    if (mplier_r[0]) begin
      acc_s = acc_r + mcand_r;
    end else begin
      acc_s = acc_r;
    end
  end

`ifdef ALU_DIV_EN
  // One restoring-divide step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
  always_comb begin
    rem_sh_s = {rem_r, quo_r[WIDTH-1]};
    trial_s  = rem_sh_s - {1'b0, dvsr_r};
    rem_s    = rem_sh_s[WIDTH-1:0];
    quo_s    = {quo_r[WIDTH-2:0], 1'b0};
    if (trial_s[WIDTH]) begin
      rem_s = rem_sh_s[WIDTH-1:0];
      quo_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_s = trial_s[WIDTH-1:0];
      quo_s = {quo_r[WIDTH-2:0], 1'b1};
    end
  end
`endif

  // Result select for the final iteration.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    if (is_mul_r) begin
      result = acc_s[WIDTH-1:0];
      ovf    = |acc_s[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
    end else if (is_mod_r) begin
      result = rem_s;
      ovf    = 1'b0;
    end else begin
      result = quo_s;
      ovf    = 1'b0;
    end
`else
    end else begin
      result = '0;
      ovf    = 1'b0;
    end
`endif
  end

  assign done = busy_r && (cnt_r == '0) && !abort;

  // Operand load on start, then one iteration per cycle until the count expires or abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r   <= 1'b0;
      cnt_r    <= '0;
      is_mul_r <= 1'b0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
`ifdef ALU_DIV_EN
      is_mod_r <= 1'b0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr_r   <= '0;
`endif
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt_r    <= CNT_W'(WIDTH - 1);
      is_mul_r <= (op == OP_MUL);
      acc_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
`ifdef ALU_DIV_EN
      is_mod_r <= (op == OP_MOD);
      rem_r    <= '0;
      quo_r    <= a;
      dvsr_r   <= b;
`endif
    end else if (abort) begin
      busy_r <= 1'b0;
    end else if (busy_r) begin
      acc_r    <= acc_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
`ifdef ALU_DIV_EN
      rem_r    <= rem_s;
      quo_r    <= quo_s;
`endif
      if (cnt_r == '0) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mc_core.sv
// Multi-cycle ALU core: single-cycle datapath, IDLE/BUSY FSM, flag generation
// and registered result/status. Build switch ALU_DIV_EN adds DIV/MOD.
module alu_mc_core #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          reset_n,
  alu_mc_core_if.slave bus
);
  import alu_mc_core_pkg::*;

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e       state_r, state_s;
  logic             accept_s, mc_op_s, md_start_s, md_done_s, md_ovf_s;
  logic [WIDTH-1:0] md_result_s;
  logic [4:0]       md_stat_s;
  logic [WIDTH-1:0] out_r;
  logic [4:0]       status_r;
  logic             valid_r;
  logic [4:0]       op_r;
  logic             b_zero_r;
  logic [SH_W-1:0]  amt_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH:0]   sum_s, diff_s, shl_s, shr_s, sar_s;
  logic [WIDTH-1:0] rol_s, ror_s;
  logic [WIDTH-1:0] sc_out_s, flag_src_s;
  logic             sc_c_s, sc_v_s, sc_err_s, use_diff_s;
  logic [4:0]       sc_stat_s;

  assign accept_s   = bus.alu_enable && (state_r == IDLE);
  assign mc_op_s    = is_multicycle(bus.alu_op);
  assign md_start_s = accept_s && mc_op_s;

  assign bus.alu_ready  = (state_r == IDLE);
  assign bus.alu_valid  = valid_r;
  assign bus.alu_out    = out_r;
  assign bus.alu_status = status_r;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (md_start_s),
    .op     (bus.alu_op),
    .a      (bus.alu_in1),
    .b      (bus.alu_in2),
    .abort  (bus.alu_abort),
    .done   (md_done_s),
    .result (md_result_s),
    .ovf    (md_ovf_s)
  );

  // Single-cycle datapath and flags; CMP reports flags of in1-in2 while passing in1 through.
  always_comb begin
    amt_s      = bus.alu_in2[SH_W-1:0];
    addend_s   = bus.alu_in2;
    if ((bus.alu_op == OP_INC) || (bus.alu_op == OP_DEC)) begin
      addend_s = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      addend_s = bus.alu_in2;
    end
    sum_s      = {1'b0, bus.alu_in1} + {1'b0, addend_s};
    diff_s     = {1'b0, bus.alu_in1} - {1'b0, addend_s};
    shl_s      = {1'b0, bus.alu_in1} << amt_s;
    shr_s      = {bus.alu_in1, 1'b0} >> amt_s;
    sar_s      = $unsigned($signed({bus.alu_in1, 1'b0}) >>> amt_s);
    rol_s      = (bus.alu_in1 << amt_s) | (bus.alu_in1 >> (WIDTH - int'(amt_s)));
    ror_s      = (bus.alu_in1 >> amt_s) | (bus.alu_in1 << (WIDTH - int'(amt_s)));
    sc_out_s   = '0;
    sc_c_s     = 1'b0;
    sc_v_s     = 1'b0;
    sc_err_s   = 1'b0;
    use_diff_s = 1'b0;
    case (bus.alu_op)
      OP_ADD, OP_INC: begin
        sc_out_s = sum_s[WIDTH-1:0];
        sc_c_s   = sum_s[WIDTH];
        sc_v_s   = (bus.alu_in1[WIDTH-1] == addend_s[WIDTH-1]) &&
                   (sum_s[WIDTH-1] != bus.alu_in1[WIDTH-1]);
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        sc_out_s   = (bus.alu_op == OP_CMP) ? bus.alu_in1 : diff_s[WIDTH-1:0];
        use_diff_s = 1'b1;
        sc_c_s     = diff_s[WIDTH];
        sc_v_s     = (bus.alu_in1[WIDTH-1] != addend_s[WIDTH-1]) &&
                     (diff_s[WIDTH-1] != bus.alu_in1[WIDTH-1]);
      end
      OP_AND: sc_out_s = bus.alu_in1 & bus.alu_in2;
      OP_OR:  sc_out_s = bus.alu_in1 | bus.alu_in2;
      OP_XOR: sc_out_s = bus.alu_in1 ^ bus.alu_in2;
      OP_NOT: sc_out_s = ~bus.alu_in1;
      OP_SHL: begin
        sc_out_s = shl_s[WIDTH-1:0];
        sc_c_s   = shl_s[WIDTH];
      end
      OP_SHR: begin
        sc_out_s = shr_s[WIDTH:1];
        sc_c_s   = shr_s[0];
      end
      OP_SAR: begin
        sc_out_s = sar_s[WIDTH:1];
        sc_c_s   = sar_s[0];
      end
      OP_ROL: begin
        sc_out_s = rol_s;
        sc_c_s   = (amt_s != {SH_W{1'b0}}) && rol_s[0];
      end
      OP_ROR: begin
        sc_out_s = ror_s;
        sc_c_s   = (amt_s != {SH_W{1'b0}}) && ror_s[WIDTH-1];
      end
      default: begin
        sc_out_s = '0;
        sc_err_s = 1'b1;
      end
    endcase
    if (use_diff_s) begin
      flag_src_s = diff_s[WIDTH-1:0];
    end else begin
      flag_src_s = sc_out_s;
    end
    sc_stat_s = {sc_err_s, sc_v_s, sc_c_s, flag_src_s[WIDTH-1], (flag_src_s == '0)};
  end

  // Flags for an iterative result; a zero divisor on DIV/MOD raises ERR.
  always_comb begin
    md_stat_s = '0;
    md_stat_s[STAT_Z]   = (md_result_s == '0);
    md_stat_s[STAT_N]   = md_result_s[WIDTH-1];
    md_stat_s[STAT_C]   = md_ovf_s;
    md_stat_s[STAT_V]   = md_ovf_s;
    md_stat_s[STAT_ERR] = (op_r != OP_MUL) && b_zero_r;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; abort takes priority over a completion in the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (md_start_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.alu_abort || md_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output registers: load on single-cycle accept or iterative completion, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_r    <= '0;
      status_r <= '0;
      valid_r  <= 1'b0;
      op_r     <= '0;
      b_zero_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (accept_s) begin
        op_r     <= bus.alu_op;
        b_zero_r <= (bus.alu_in2 == '0);
      end
      if (accept_s && !mc_op_s) begin
        out_r    <= sc_out_s;
        status_r <= sc_stat_s;
        valid_r  <= 1'b1;
      end else if ((state_r == BUSY) && md_done_s) begin
        out_r    <= md_result_s;
        status_r <= md_stat_s;
        valid_r  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc_core.sv
// Directed bench for alu_mc_core: vector table for single-cycle ops plus
// hand-written multi-cycle, abort and reset sequences (WIDTH=8 and WIDTH=16).
module tb_alu_mc_core;
  import alu_mc_core_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_mc_core_if #(.WIDTH(8))  bus8 ();
  alu_mc_core_if #(.WIDTH(16)) bus16 ();

  alu_mc_core #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8));
  alu_mc_core #(.WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic [4:0] exp_st;
    logic [4:0] mask;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present one request for one cycle; returns at the sample point of cycle T+1.
  task automatic issue8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    bus8.alu_enable = 1'b1; bus8.alu_op = op; bus8.alu_in1 = a; bus8.alu_in2 = b;
    @(posedge clk); #1;
    bus8.alu_enable = 1'b0;
  endtask

  // Bounded wait for alu_valid; lat counts cycles from accept (1 = T+1).
  task automatic wait_valid8(output int lat, output int busy);
    lat = 1; busy = 0;
    while (bus8.alu_valid !== 1'b1 && lat < 40) begin
      if (bus8.alu_ready === 1'b0) busy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input string nm, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eo, input logic [4:0] es, input logic [4:0] m, input int el);
    int lat, busy;
    issue8(op, a, b);
    wait_valid8(lat, busy);
    chk({nm, " latency"}, lat, el);
    chk({nm, " busy cycles"}, busy, el - 1);
    chk({nm, " out"}, bus8.alu_out, eo);
    chk({nm, " status"}, bus8.alu_status & m, es & m);
  endtask

  initial begin
    int lat, nvalid;
    // op, a, b, exp_out, exp_status {ERR,V,C,N,Z}, mask
    vecs[0]  = '{OP_ADD, 8'h03, 8'h04, 8'h07, 5'b00000, 5'b11111};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 5'b00101, 5'b11111};
    vecs[2]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 5'b01000, 5'b11111};
    vecs[3]  = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 5'b00110, 5'b11111};
    vecs[4]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 5'b00000, 5'b11111};
    vecs[5]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 5'b00010, 5'b11111};
    vecs[6]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 5'b00001, 5'b11111};
    vecs[7]  = '{OP_NOT, 8'h0F, 8'h00, 8'hF0, 5'b00010, 5'b11111};
    vecs[8]  = '{OP_SHL, 8'h81, 8'h01, 8'h02, 5'b00100, 5'b11111};
    vecs[9]  = '{OP_SHR, 8'h81, 8'h01, 8'h40, 5'b00100, 5'b11111};
    vecs[10] = '{OP_SAR, 8'h81, 8'h01, 8'hC0, 5'b00110, 5'b11111};
    vecs[11] = '{OP_ROL, 8'h81, 8'h01, 8'h03, 5'b00100, 5'b11111};
    vecs[12] = '{OP_ROR, 8'h01, 8'h01, 8'h80, 5'b00110, 5'b11111};
    vecs[13] = '{OP_SHL, 8'h81, 8'h00, 8'h81, 5'b00010, 5'b11111};
    vecs[14] = '{OP_SHL, 8'h01, 8'h09, 8'h02, 5'b00000, 5'b11111};
    vecs[15] = '{OP_CMP, 8'h80, 8'h01, 8'h80, 5'b01000, 5'b11100};
    vecs[16] = '{OP_INC, 8'h7F, 8'h00, 8'h80, 5'b01010, 5'b11111};
    vecs[17] = '{OP_DEC, 8'h00, 8'h00, 8'hFF, 5'b00110, 5'b11111};
    vecs[18] = '{OP_INC, 8'hFF, 8'h00, 8'h00, 5'b00101, 5'b11111};
    vecs[19] = '{5'h1F,  8'h12, 8'h34, 8'h00, 5'b10000, 5'b10000};

    bus8.alu_enable = 1'b0; bus8.alu_op = 5'h00; bus8.alu_in1 = 8'h00;
    bus8.alu_in2 = 8'h00; bus8.alu_abort = 1'b0;
    bus16.alu_enable = 1'b0; bus16.alu_op = 5'h00; bus16.alu_in1 = 16'h0000;
    bus16.alu_in2 = 16'h0000; bus16.alu_abort = 1'b0;

    // Reset values, including while reset_n is held low
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #20;
    chk("reset out", bus8.alu_out, 8'h00);
    chk("reset status", bus8.alu_status, 5'h00);
    chk("reset valid", bus8.alu_valid, 1'b0);
    chk("reset ready", bus8.alu_ready, 1'b1);
    @(negedge clk) reset_n = 1'b1;
    run8("first add", OP_ADD, 8'h03, 8'h04, 8'h07, 5'b00000, 5'b11111, 1);

    // Single-cycle vectors, one per clock back to back
    @(posedge clk); #1;
    bus8.alu_enable = 1'b1; bus8.alu_op = vecs[0].op;
    bus8.alu_in1 = vecs[0].a; bus8.alu_in2 = vecs[0].b;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid", i), bus8.alu_valid, 1'b1);
      chk($sformatf("vec%0d out", i), bus8.alu_out, vecs[i].exp_out);
      chk($sformatf("vec%0d status", i), bus8.alu_status & vecs[i].mask, vecs[i].exp_st & vecs[i].mask);
      if (i < NV - 1) begin
        bus8.alu_op = vecs[i+1].op; bus8.alu_in1 = vecs[i+1].a; bus8.alu_in2 = vecs[i+1].b;
      end else begin
        bus8.alu_enable = 1'b0;
      end
    end

    // MUL with an enable during BUSY that must be ignored
    issue8(OP_MUL, 8'h10, 8'h11);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("mul ready T+%0d", k), bus8.alu_ready, 1'b0);
      chk($sformatf("mul valid T+%0d", k), bus8.alu_valid, 1'b0);
      if (k == 3) begin
        bus8.alu_enable = 1'b1; bus8.alu_op = OP_ADD; bus8.alu_in1 = 8'h01; bus8.alu_in2 = 8'h01;
      end else begin
        bus8.alu_enable = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("mul valid T+9", bus8.alu_valid, 1'b1);
    chk("mul out", bus8.alu_out, 8'h10);
    chk("mul status", bus8.alu_status, 5'b01100);
    chk("mul ready T+9", bus8.alu_ready, 1'b1);
    @(posedge clk); #1;
    chk("mul no extra valid", bus8.alu_valid, 1'b0);

`ifdef ALU_DIV_EN
    run8("div", OP_DIV, 8'h64, 8'h07, 8'h0E, 5'b00000, 5'b11111, 9);
    run8("mod", OP_MOD, 8'h64, 8'h07, 8'h02, 5'b00000, 5'b11111, 9);
    run8("div by 0", OP_DIV, 8'h55, 8'h00, 8'hFF, 5'b10010, 5'b11111, 9);
    run8("mod by 0", OP_MOD, 8'h55, 8'h00, 8'h55, 5'b10000, 5'b11111, 9);
`else
    run8("div absent", OP_DIV, 8'h64, 8'h07, 8'h00, 5'b10000, 5'b10000, 1);
    run8("mod absent", OP_MOD, 8'h64, 8'h07, 8'h00, 5'b10000, 5'b10000, 1);
`endif

    // Abort at T+4: no valid, outputs keep the previous result
    run8("pre-abort add", OP_ADD, 8'h03, 8'h04, 8'h07, 5'b00000, 5'b11111, 1);
    issue8(OP_MUL, 8'h10, 8'h11);
    for (int k = 1; k < 4; k++) begin @(posedge clk); #1; end
    bus8.alu_abort = 1'b1;
    @(posedge clk); #1;
    bus8.alu_abort = 1'b0;
    chk("abort ready T+5", bus8.alu_ready, 1'b1);
    chk("abort valid T+5", bus8.alu_valid, 1'b0);
    chk("abort out kept", bus8.alu_out, 8'h07);
    chk("abort status kept", bus8.alu_status, 5'b00000);
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus8.alu_valid === 1'b1) nvalid++;
    end
    chk("abort late valids", nvalid, 0);

    // Abort coinciding with the final count: abort wins
    issue8(OP_MUL, 8'h10, 8'h11);
    for (int k = 1; k < 8; k++) begin @(posedge clk); #1; end
    bus8.alu_abort = 1'b1;
    @(posedge clk); #1;
    bus8.alu_abort = 1'b0;
    chk("final abort valid", bus8.alu_valid, 1'b0);
    chk("final abort ready", bus8.alu_ready, 1'b1);
    chk("final abort out kept", bus8.alu_out, 8'h07);

    // Abort while IDLE has no effect
    bus8.alu_abort = 1'b1;
    run8("idle abort add", OP_ADD, 8'h01, 8'h01, 8'h02, 5'b00000, 5'b11111, 1);
    bus8.alu_abort = 1'b0;

    // Reset mid-op at T+3 clears outputs at once
    issue8(OP_MUL, 8'h10, 8'h11);
    for (int k = 1; k < 3; k++) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("midop reset out", bus8.alu_out, 8'h00);
    chk("midop reset status", bus8.alu_status, 5'h00);
    chk("midop reset valid", bus8.alu_valid, 1'b0);
    chk("midop reset ready", bus8.alu_ready, 1'b1);
    @(negedge clk) reset_n = 1'b1;
    run8("post-reset sub", OP_SUB, 8'h80, 8'h01, 8'h7F, 5'b01000, 5'b11111, 1);

    // WIDTH=16 multiply latency
    @(posedge clk); #1;
    bus16.alu_enable = 1'b1; bus16.alu_op = OP_MUL; bus16.alu_in1 = 16'h1000; bus16.alu_in2 = 16'h0011;
    @(posedge clk); #1;
    bus16.alu_enable = 1'b0;
    lat = 1;
    while (bus16.alu_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16 mul latency", lat, 17);
    chk("w16 mul out", bus16.alu_out, 16'h1000);
    chk("w16 mul status", bus16.alu_status, 5'b01100);
    chk("w16 mul ready", bus16.alu_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
